// File: rtl/ela_frame_reader.sv
// ela_frame_reader: reads one IMG_W x IMG_H frame from the result memory and
// streams it out over a valid/ready pixel port, through a 2-entry output FIFO.
module ela_frame_reader #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        rd_en,
  output logic [9:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  px_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_last,
  output logic        frame_done,
  output logic [15:0] checksum
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [10:0]   LAST_PIX = 11'(NPIX - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

  state_t          state_q, state_d;
  logic [10:0]     issue_q, issue_d;      // reads issued so far this frame
  logic            inflight_q, inflight_d; // read issued last cycle, data on rd_data now
  logic [1:0][7:0] fifo_q, fifo_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      occ_q, occ_d;
  logic [10:0]     pix_q, pix_d;          // output pixel index
  logic [CW-1:0]   col_q, col_d;          // output column within the row
  logic [15:0]     csum_q, csum_d;

  logic       accept, push, pop, credit_ok;
  logic [2:0] used;

  assign accept   = (state_q == IDLE) && start;
  assign push     = inflight_q;
  assign px_valid = (occ_q != 2'd0);
  assign px_data  = fifo_q[rd_ptr_q];
  assign px_last  = px_valid && (col_q == LAST_COL);
  assign pop      = px_valid && px_ready;
  assign checksum = csum_q;

  // Slots already spoken for: FIFO entries plus the read whose data is on
  // the bus. A pop this cycle frees a slot before the new read's data can
  // land, so it is credited immediately; that keeps one pixel per cycle
  // with only two entries while never exceeding two outstanding items.
  assign used      = {1'b0, occ_q} + {2'b0, inflight_q};
  assign credit_ok = used < (3'd2 + {2'b0, pop});

  // Present the live address while reading, otherwise hold the last issued one.
  assign rd_addr = rd_en ? issue_q[9:0]
                         : ((issue_q == 11'd0) ? 10'd0 : 10'(issue_q - 11'd1));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: if (rd_en && issue_q == LAST_PIX) state_d = DRAIN;
      DRAIN:  if (pop && pix_q == LAST_PIX) state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (state_q != IDLE);
    rd_en      = (state_q == STREAM) && credit_ok;
    frame_done = (state_q == FIN);
  end

  // Datapath next-state: read counter, FIFO, output index, checksum
  always_comb begin
    issue_d    = issue_q;
    inflight_d = rd_en;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    pix_d      = pix_q;
    col_d      = col_q;
    csum_d     = csum_q;

    if (push) fifo_d[wr_ptr_q] = rd_data;

    if (accept) begin
      issue_d = 11'd0;
      pix_d   = 11'd0;
      col_d   = '0;
      csum_d  = 16'd0;
    end else begin
      if (rd_en) issue_d = issue_q + 11'd1;
      if (pop) begin
        pix_d  = pix_q + 11'd1;
        col_d  = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
        csum_d = csum_q + {8'd0, px_data};
      end
    end
  end

  // Datapath registers; reset drops any in-flight read and empties the FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_q    <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
      pix_q      <= '0;
      col_q      <= '0;
      csum_q     <= '0;
    end else begin
      issue_q    <= issue_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      pix_q      <= pix_d;
      col_q      <= col_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_ela_frame_reader.sv
// tb_ela_frame_reader: directed scenarios for the frame reader with a
// one-cycle-latency memory model (mem[i] = i[7:0] ^ key).
module tb_ela_frame_reader;

  localparam int W    = 32;
  localparam int H    = 31;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        px_ready = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic        busy, rd_en, px_valid, px_last, frame_done;
  logic [9:0]  rd_addr;
  logic [7:0]  px_data;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  key = 8'd0;
  int          exp_idx, exp_addr, issued, done_cnt;
  int          first_rd, first_val, last_acc, s_cyc;
  logic [15:0] sum_model;
  bit          hold_prev, last_prev;
  logic [7:0]  data_prev;
  logic        lastbit_prev;

  ela_frame_reader #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .px_data(px_data),
    .px_valid(px_valid), .px_ready(px_ready), .px_last(px_last),
    .frame_done(frame_done), .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // result memory: data valid the cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0] ^ key;

  // One cycle of streaming with per-cycle checks; enters and leaves at posedge+1.
  task automatic step(input int mode);
    bit         acc;
    bit         fin;
    logic [7:0] e;
    case (mode)
      0:       px_ready = 1'b0;
      1:       px_ready = 1'b1;
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    acc = px_valid && px_ready;
    fin = 1'b0;
    if (hold_prev) begin
      n_checks++;
      if (px_valid !== 1'b1 || px_data !== data_prev || px_last !== lastbit_prev) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 cyc, px_valid, px_data, px_last, data_prev, lastbit_prev);
      end
    end
    if (rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      n_checks++;
      if (int'(rd_addr) != exp_addr) begin
        n_fail++;
        $display("FAIL rd_addr cyc=%0d got %0d want %0d", cyc, rd_addr, exp_addr);
      end
      exp_addr++;
      issued++;
    end
    if (px_valid && first_val < 0) first_val = cyc;
    if (acc) begin
      e = 8'(exp_idx) ^ key;
      n_checks++;
      if (px_data !== e || px_last !== ((exp_idx % W) == W - 1)) begin
        n_fail++;
        $display("FAIL pixel idx=%0d got d=%h l=%b want d=%h l=%b",
                 exp_idx, px_data, px_last, e, (exp_idx % W) == W - 1);
      end
      sum_model = sum_model + {8'd0, e};
      if (exp_idx == NPIX - 1) begin
        last_acc = cyc;
        fin = 1'b1;
      end
      exp_idx++;
    end
    n_checks++;
    if (issued - exp_idx > 2 || int'(rd_addr) > NPIX - 1) begin
      n_fail++;
      $display("FAIL credit cyc=%0d got outstanding=%0d addr=%0d want <=2 and <=%0d",
               cyc, issued - exp_idx, rd_addr, NPIX - 1);
    end
    if (frame_done || last_prev) begin
      n_checks++;
      if (frame_done !== last_prev) begin
        n_fail++;
        $display("FAIL frame_done cyc=%0d got %b want %b", cyc, frame_done, last_prev);
      end
    end
    if (frame_done) done_cnt++;
    last_prev    = fin;
    hold_prev    = px_valid && !px_ready;
    data_prev    = px_data;
    lastbit_prev = px_last;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_idx = 0; exp_addr = 0; issued = 0; done_cnt = 0;
    first_rd = -1; first_val = -1; last_acc = -1;
    sum_model = 16'd0; hold_prev = 1'b0; last_prev = 1'b0;
  endtask

  // start sampled at edge N; s_cyc is the cycle that edge N+1 closes
  task automatic pulse_start();
    clear_model();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic run_frame(input int mode, input int limit);
    int n;
    n = 0;
    while (done_cnt == 0 && n < limit) begin
      step(mode);
      n++;
    end
    repeat (4) step(1);
    n_checks++;
    if (done_cnt != 1 || exp_idx != NPIX || exp_addr != NPIX) begin
      n_fail++;
      $display("FAIL frame_end got done=%0d pixels=%0d reads=%0d want 1/%0d/%0d",
               done_cnt, exp_idx, exp_addr, NPIX, NPIX);
    end
    n_checks++;
    if (checksum !== sum_model) begin
      n_fail++;
      $display("FAIL checksum got %h want %h", checksum, sum_model);
    end
    n_checks++;
    if (busy !== 1'b0 || rd_addr !== 10'(NPIX - 1)) begin
      n_fail++;
      $display("FAIL idle_after got busy=%b addr=%0d want 0/%0d", busy, rd_addr, NPIX - 1);
    end
  endtask

  task automatic quiet_cycles(input int n, output int bad);
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy || rd_en || px_valid || frame_done) bad++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, rd_en, rd_addr, px_valid, px_data, px_last, frame_done, checksum} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want all zero",
               {busy, rd_en, rd_addr, px_valid, px_data, px_last, frame_done, checksum});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    quiet_cycles(5, bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_quiet got %0d active cycles want 0", bad);
    end
  endtask

  // mem[i]=i, ready high: latency, ordering, px_last, throughput, checksum
  task automatic test_full_frame();
    key = 8'h00;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on_start got %b want 1", busy);
    end
    run_frame(1, 1500);
    n_checks++;
    if (first_rd - s_cyc != 0 || first_val - s_cyc != 2) begin
      n_fail++;
      $display("FAIL latency got rd=+%0d valid=+%0d want +0/+2",
               first_rd - s_cyc, first_val - s_cyc);
    end
    n_checks++;
    if (last_acc - first_val != NPIX - 1) begin
      n_fail++;
      $display("FAIL throughput got %0d cycles want %0d", last_acc - first_val, NPIX - 1);
    end
    // 3*sum(0..255) + sum(0..223) = 122896 -> mod 2^16 = 0xE010
    n_checks++;
    if (checksum !== 16'hE010) begin
      n_fail++;
      $display("FAIL checksum_const got %h want E010", checksum);
    end
  endtask

  task automatic test_random_ready();
    key = 8'h5A;
    pulse_start();
    run_frame(2, 6000);
  endtask

  task automatic test_stall();
    int n;
    int rel;
    key = 8'h33;
    px_ready = 1'b0;
    pulse_start();
    n = 0;
    while (first_val < 0 && n < 10) begin
      step(0);
      n++;
    end
    repeat (20) step(0);
    n_checks++;
    if (issued != 2 || px_valid !== 1'b1 || px_data !== 8'h33) begin
      n_fail++;
      $display("FAIL stall_reads got reads=%0d v=%b d=%h want 2/1/33", issued, px_valid, px_data);
    end
    rel = cyc;
    run_frame(1, 1500);
    n_checks++;
    if (last_acc - rel != NPIX - 1) begin
      n_fail++;
      $display("FAIL stall_resume got %0d cycles want %0d", last_acc - rel, NPIX - 1);
    end
  endtask

  task automatic test_double_start();
    key = 8'hC3;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) start = 1'b1;
      step(1);
      start = 1'b0;
    end
    run_frame(1, 1500);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int bad;
    logic [15:0] cs_before;
    key = 8'h00;
    pulse_start();
    n = 0;
    while (exp_idx < 500 && n < 2000) begin
      step(1);
      n++;
    end
    cs_before = checksum;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (cs_before === 16'd0 ||
        {busy, rd_en, rd_addr, px_valid, px_data, px_last, frame_done, checksum} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got cs_before=%h outs=%b want nonzero/all zero", cs_before,
               {busy, rd_en, rd_addr, px_valid, px_data, px_last, frame_done, checksum});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    quiet_cycles(5, bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d active cycles want 0", bad);
    end
    key = 8'h77;
    pulse_start();
    run_frame(2, 6000);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_full_frame();
    test_random_ready();
    test_stall();
    test_double_start();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
